// File: rtl/core_sequencer.sv
// Multi-cycle fetch/decode/execute sequencer for the 16-bit core. Owns pc and ir,
// handshakes with instruction ROM and data memory, and strobes register-file writes.
//
//   state   | meaning
//   --------+--------------------------------------------------------------
//   FETCH   | rom_req high, wait for rom_ack, latch ir, pc <= pc + 1
//   DECODE  | one cycle, register addresses valid from ir
//   EXEC    | ALU write / branch resolve / NOP / illegal flag / HALT entry
//   MEM     | mem_req high until mem_ack (load or store)
//   WB      | load write-back, one-cycle rf_we
//   HALT    | halted high, no requests, left only through reset
module core_sequencer #(
  parameter int              PC_W     = 8,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            clock_50,
  input  logic            reset_n,
  output logic            rom_req,
  input  logic            rom_ack,
  input  logic [15:0]     rom_data,
  output logic [PC_W-1:0] pc,
  output logic [15:0]     ir,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ack,
  output logic            rf_we,
  output logic [2:0]      rf_da,
  output logic [2:0]      rf_aa,
  output logic [2:0]      rf_ba,
  output logic [3:0]      alu_op,
  input  logic            cout,
  input  logic            z,
  input  logic            n,
  output logic            halted,
  output logic            illegal
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  localparam logic [3:0] OP_NOP   = 4'h0;
  localparam logic [3:0] OP_ALU   = 4'h1;
  localparam logic [3:0] OP_LOAD  = 4'h2;
  localparam logic [3:0] OP_STORE = 4'h3;
  localparam logic [3:0] OP_BR    = 4'h4;
  localparam logic [3:0] OP_BZ    = 4'h5;
  localparam logic [3:0] OP_BN    = 4'h6;
  localparam logic [3:0] OP_BC    = 4'h7;
  localparam logic [3:0] OP_HALT  = 4'hF;

  state_t          state;
  logic [3:0]      opcode;
  logic [PC_W-1:0] target;
  logic            taken;

  assign opcode = ir[15:12];
  assign target = PC_W'(ir[7:0]);
  assign rf_da  = ir[11:9];
  assign rf_aa  = ir[8:6];
  assign rf_ba  = ir[5:3];
  assign alu_op = (opcode == OP_ALU) ? ir[3:0] : 4'h0;

  always_comb begin
    taken = 1'b0;
    case (opcode)
      OP_BR:   taken = 1'b1;
      OP_BZ:   taken = z;
      OP_BN:   taken = n;
      OP_BC:   taken = cout;
      default: taken = 1'b0;
    endcase
  end

  // Request/strobe outputs are registered so they always line up with the state they belong to.
  always_ff @(posedge clock_50 or negedge reset_n) begin
    if (!reset_n) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      ir      <= 16'h0000;
      rom_req <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      rf_we   <= 1'b0;
      halted  <= 1'b0;
      illegal <= 1'b0;
    end else begin
      rf_we <= 1'b0;
      case (state)
        S_FETCH: begin
          if (rom_req && rom_ack) begin
            ir      <= rom_data;
            pc      <= pc + PC_W'(1);
            rom_req <= 1'b0;
            state   <= S_DECODE;
          end else begin
            rom_req <= 1'b1;
          end
        end
        S_DECODE: begin
          rf_we <= (opcode == OP_ALU);
          state <= S_EXEC;
        end
        S_EXEC: begin
          case (opcode)
            OP_NOP, OP_ALU: begin
              rom_req <= 1'b1;
              state   <= S_FETCH;
            end
            OP_BR, OP_BZ, OP_BN, OP_BC: begin
              if (taken) pc <= target;
              rom_req <= 1'b1;
              state   <= S_FETCH;
            end
            OP_LOAD, OP_STORE: begin
              mem_req <= 1'b1;
              mem_we  <= (opcode == OP_STORE);
              state   <= S_MEM;
            end
            OP_HALT: begin
              halted <= 1'b1;
              state  <= S_HALT;
            end
            default: begin
              illegal <= 1'b1;
              rom_req <= 1'b1;
              state   <= S_FETCH;
            end
          endcase
        end
        S_MEM: begin
          if (mem_req && mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (mem_we) begin
              rom_req <= 1'b1;
              state   <= S_FETCH;
            end else begin
              rf_we <= 1'b1;
              state <= S_WB;
            end
          end
        end
        S_WB: begin
          rom_req <= 1'b1;
          state   <= S_FETCH;
        end
        S_HALT: state <= S_HALT;
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_core_sequencer.sv
// Bench for core_sequencer: table of directed instructions, a random instruction
// stream checked against an instruction-level model, and hand-written reset sequences.
module tb_core_sequencer;

  logic        clock_50 = 1'b0;
  logic        reset_n  = 1'b0;
  logic        rom_req;
  logic        rom_ack  = 1'b0;
  logic [15:0] rom_data = 16'h0000;
  logic [7:0]  pc;
  logic [15:0] ir;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ack  = 1'b0;
  logic        rf_we;
  logic [2:0]  rf_da;
  logic [2:0]  rf_aa;
  logic [2:0]  rf_ba;
  logic [3:0]  alu_op;
  logic        cout = 1'b0;
  logic        z    = 1'b0;
  logic        n    = 1'b0;
  logic        halted;
  logic        illegal;

  int   n_checks = 0;
  int   n_fails  = 0;
  logic [7:0] model_pc = 8'h00;
  logic       model_illegal = 1'b0;

  core_sequencer #(.PC_W(8), .RESET_PC(8'h00)) dut (
    .clock_50(clock_50), .reset_n(reset_n),
    .rom_req(rom_req), .rom_ack(rom_ack), .rom_data(rom_data), .pc(pc), .ir(ir),
    .mem_req(mem_req), .mem_we(mem_we), .mem_ack(mem_ack),
    .rf_we(rf_we), .rf_da(rf_da), .rf_aa(rf_aa), .rf_ba(rf_ba), .alu_op(alu_op),
    .cout(cout), .z(z), .n(n), .halted(halted), .illegal(illegal)
  );

  always #5 clock_50 = ~clock_50;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Reset, check reset values, release on a falling edge, confirm a stray ack is ignored.
  task automatic do_reset();
    reset_n = 1'b0;
    rom_ack = 1'b0;
    mem_ack = 1'b0;
    repeat (2) @(negedge clock_50);
    check("reset_pc", 32'(pc), 32'h00);
    check("reset_ir", 32'(ir), 32'h0000);
    check("reset_ctl", 32'({rom_req, mem_req, mem_we, rf_we, halted, illegal}), 32'h0);
    reset_n = 1'b1;
    rom_ack = 1'b1;
    rom_data = 16'h1FFF;
    @(negedge clock_50);
    check("stray_ack_ir", 32'(ir), 32'h0000);
    check("stray_ack_pc", 32'(pc), 32'h00);
    check("req_after_reset", 32'(rom_req), 32'h1);
    rom_ack = 1'b0;
    model_pc = 8'h00;
    model_illegal = 1'b0;
  endtask

  // Feed one instruction at the current fetch and follow it until the next fetch request.
  task automatic exec_instr(input logic [15:0] word, input int rom_w, input int mem_w,
                            input logic [2:0] flg, output int got_cyc);
    logic [3:0] op;
    logic [7:0] exp_pc;
    int exp_cyc, exp_we, exp_mem, cyc, we_cnt, we_at, mem_cnt, bad;
    bit done;
    op = word[15:12];
    {cout, z, n} = flg;
    exp_pc = model_pc + 8'd1;
    exp_cyc = 3;
    exp_we = 0;
    exp_mem = 0;
    case (op)
      4'h0: ;
      4'h1: exp_we = 1;
      4'h2: begin exp_we = 1; exp_mem = mem_w + 1; exp_cyc = 5 + mem_w; end
      4'h3: begin exp_mem = mem_w + 1; exp_cyc = 4 + mem_w; end
      4'h4: exp_pc = word[7:0];
      4'h5: if (flg[1]) exp_pc = word[7:0];
      4'h6: if (flg[0]) exp_pc = word[7:0];
      4'h7: if (flg[2]) exp_pc = word[7:0];
      4'hF: exp_cyc = 0;
      default: model_illegal = 1'b1;
    endcase

    cyc = 0;
    while (!rom_req && cyc < 10) begin
      rom_ack = 1'b0;
      @(negedge clock_50);
      cyc++;
    end
    check("fetch_req", 32'(rom_req), 32'h1);
    check("fetch_pc", 32'(pc), 32'(model_pc));
    bad = 0;
    for (int i = 0; i < rom_w; i++) begin
      rom_ack = 1'b0;
      rom_data = 16'($urandom);
      @(negedge clock_50);
      if (!rom_req || pc !== model_pc) bad++;
    end
    check("fetch_hold", 32'(bad), 32'h0);
    rom_ack = 1'b1;
    rom_data = word;

    cyc = 0; we_cnt = 0; we_at = -1; mem_cnt = 0; bad = 0; done = 1'b0;
    while (!done) begin
      @(negedge clock_50);
      cyc++;
      if (rom_req && mem_req) bad++;
      if (cyc == 1) begin
        check("ir_latch", 32'(ir), 32'(word));
        check("rf_addr", 32'({rf_da, rf_aa, rf_ba}), 32'({word[11:9], word[8:6], word[5:3]}));
        check("alu_op", 32'(alu_op), 32'((op == 4'h1) ? word[3:0] : 4'h0));
      end
      if (mem_req) begin
        mem_cnt++;
        if (mem_we !== (op == 4'h3)) bad++;
        mem_ack = (mem_cnt == mem_w + 1);
      end else begin
        mem_ack = 1'($urandom_range(0, 1));
      end
      if (rf_we) begin
        we_cnt++;
        we_at = cyc;
        if (rf_da !== word[11:9]) bad++;
        if (alu_op !== ((op == 4'h1) ? word[3:0] : 4'h0)) bad++;
      end
      if (op == 4'hF) begin
        if (rom_req || mem_req) bad++;
        if (cyc >= 3 && !halted) bad++;
        done = (cyc >= 50);
      end else begin
        done = rom_req || (cyc >= 60);
      end
      rom_ack = rom_req ? 1'b0 : 1'($urandom_range(0, 1));
    end

    check("protocol", 32'(bad), 32'h0);
    if (op != 4'hF) begin
      check("latency", 32'(cyc), 32'(exp_cyc));
      check("rf_we_count", 32'(we_cnt), 32'(exp_we));
      if (exp_we != 0) check("rf_we_slot", 32'(we_at), 32'(exp_cyc - 1));
      check("mem_cycles", 32'(mem_cnt), 32'(exp_mem));
      check("next_pc", 32'(pc), 32'(exp_pc));
      got_cyc = cyc;
    end else begin
      check("halted", 32'(halted), 32'h1);
      check("halt_rf_we", 32'(we_cnt), 32'h0);
      got_cyc = 0;
    end
    check("illegal", 32'(illegal), 32'(model_illegal));
    model_pc = exp_pc;
    rom_ack = 1'b0;
    mem_ack = 1'b0;
  endtask

  typedef struct {
    logic [15:0] word;
    int          rom_w;
    int          mem_w;
    logic [2:0]  flg;      // {cout, z, n}
    logic [7:0]  exp_pc;
    int          exp_cyc;
    logic        exp_ill;
  } vec_t;

  vec_t tbl[13];

  initial begin
    int got;
    logic [11:0] lo;
    logic [3:0]  op;

    tbl[0]  = '{16'h1A43, 0, 0, 3'b000, 8'h01, 3, 1'b0};
    tbl[1]  = '{16'h2280, 1, 2, 3'b000, 8'h02, 7, 1'b0};
    tbl[2]  = '{16'h5042, 0, 0, 3'b010, 8'h42, 3, 1'b0};
    tbl[3]  = '{16'h5042, 2, 0, 3'b000, 8'h43, 3, 1'b0};
    tbl[4]  = '{16'h40FF, 0, 0, 3'b000, 8'hFF, 3, 1'b0};
    tbl[5]  = '{16'h0000, 0, 0, 3'b111, 8'h00, 3, 1'b0};
    tbl[6]  = '{16'h3A50, 0, 0, 3'b000, 8'h01, 4, 1'b0};
    tbl[7]  = '{16'h6010, 0, 0, 3'b001, 8'h10, 3, 1'b0};
    tbl[8]  = '{16'h7020, 0, 0, 3'b011, 8'h11, 3, 1'b0};
    tbl[9]  = '{16'h7020, 0, 0, 3'b100, 8'h20, 3, 1'b0};
    tbl[10] = '{16'h4020, 0, 0, 3'b000, 8'h20, 3, 1'b0};
    tbl[11] = '{16'h9000, 0, 0, 3'b000, 8'h21, 3, 1'b1};
    tbl[12] = '{16'h1123, 2, 0, 3'b000, 8'h22, 3, 1'b1};

    do_reset();
    for (int i = 0; i < 13; i++) begin
      exec_instr(tbl[i].word, tbl[i].rom_w, tbl[i].mem_w, tbl[i].flg, got);
      check($sformatf("tbl%0d_cycles", i), 32'(got), 32'(tbl[i].exp_cyc));
      check($sformatf("tbl%0d_pc", i), 32'(pc), 32'(tbl[i].exp_pc));
      check($sformatf("tbl%0d_illegal", i), 32'(illegal), 32'(tbl[i].exp_ill));
    end

    for (int i = 0; i < 200; i++) begin
      op = 4'($urandom_range(0, 8));
      if (op == 4'h8) op = 4'($urandom_range(8, 14));
      lo = 12'($urandom);
      exec_instr({op, lo}, $urandom_range(0, 3), $urandom_range(0, 3), 3'($urandom), got);
    end

    exec_instr(16'hF000, 0, 0, 3'b000, got);

    // Reset while the memory request is waiting for its ack.
    do_reset();
    rom_ack = 1'b1;
    rom_data = 16'h2280;
    for (int i = 0; i < 10 && !mem_req; i++) begin
      @(negedge clock_50);
      rom_ack = 1'b0;
    end
    check("mem_wait_req", 32'(mem_req), 32'h1);
    mem_ack = 1'b0;
    @(negedge clock_50);
    #2 reset_n = 1'b0;
    #1;
    check("mem_req_async_drop", 32'(mem_req), 32'h0);
    check("mem_reset_ctl", 32'({rom_req, rf_we, mem_we}), 32'h0);
    check("mem_reset_pc", 32'(pc), 32'h00);
    do_reset();
    exec_instr(16'h1A43, 0, 0, 3'b000, got);
    check("after_mem_reset_cycles", 32'(got), 32'd3);

    // Reset while the fetch request is waiting for its ack.
    rom_ack = 1'b0;
    @(negedge clock_50);
    check("fetch_wait_req", 32'(rom_req), 32'h1);
    #2 reset_n = 1'b0;
    #1;
    check("rom_req_async_drop", 32'(rom_req), 32'h0);
    check("fetch_reset_pc", 32'(pc), 32'h00);
    do_reset();
    exec_instr(16'h0000, 0, 0, 3'b000, got);
    check("after_fetch_reset_pc", 32'(pc), 32'h01);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
